nmi_bus_arb: RTL and testbench

Two-master arbiter that shares the native (NMI) peripheral bus between the CPU port and the DMA engine's master port. It sits in front of the native-IP address decoder. It grants one outstanding transfer at a time with round-robin fairness. A bus watchdog terminates transfers the addressed slave never answers, so a bad address cannot hang either master.

---
 rtl/nmi_bus_arb.sv | 175 +++++++++++++++++
 tb/tb_nmi_bus_arb.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmi_bus_arb.sv
// Two-master round-robin arbiter for the native peripheral bus (CPU vs DMA).
// One outstanding transfer at a time; a watchdog ends transfers the slave never answers.
module nmi_bus_arb #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // CPU request port
  input  logic        cpu_valid_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_wstrb_i,
  output logic        cpu_ready_o,
  output logic [31:0] cpu_rdata_o,
  // DMA request port
  input  logic        dma_valid_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  input  logic [3:0]  dma_wstrb_i,
  output logic        dma_ready_o,
  output logic [31:0] dma_rdata_o,
  // Shared downstream port
  output logic        slv_valid_o,
  output logic [31:0] slv_addr_o,
  output logic [31:0] slv_wdata_o,
  output logic [3:0]  slv_wstrb_o,
  input  logic        slv_ready_i,
  input  logic [31:0] slv_rdata_i,
  // Error status
  input  logic        err_clr_i,
  output logic        err_o,
  output logic        err_mst_o,
  output logic [31:0] err_addr_o,
  output logic        busy_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e        state_q;
  logic          gnt_q;
  logic          rr_ptr_q;
  logic [CW-1:0] tmo_cnt_q;
  logic          err_q;
  logic          err_mst_q;
  logic [AW-1:0] err_addr_q;

  logic          busy;
  logic          mst_valid;
  logic [AW-1:0] mst_addr;
  logic [DW-1:0] mst_wdata;
  logic [SW-1:0] mst_wstrb;
  logic          xfer_live;
  logic          slv_done;
  logic          tmo_hit;
  logic          mst_ready;
  logic [DW-1:0] mst_rdata;

  // Granted-master mux, completion/timeout decode and response routing.
  always_comb begin
    busy        = 1'b0;
    mst_valid   = 1'b0;
    mst_addr    = '0;
    mst_wdata   = '0;
    mst_wstrb   = '0;
    xfer_live   = 1'b0;
    slv_done    = 1'b0;
    tmo_hit     = 1'b0;
    mst_ready   = 1'b0;
    mst_rdata   = '0;
    slv_valid_o = 1'b0;
    slv_addr_o  = '0;
    slv_wdata_o = '0;
    slv_wstrb_o = '0;
    cpu_ready_o = 1'b0;
    cpu_rdata_o = '0;
    dma_ready_o = 1'b0;
    dma_rdata_o = '0;

    busy = (state_q == ST_BUSY);
    if (gnt_q) begin
      mst_valid = dma_valid_i;
      mst_addr  = dma_addr_i;
      mst_wdata = dma_wdata_i;
      mst_wstrb = dma_wstrb_i;
    end else begin
      mst_valid = cpu_valid_i;
      mst_addr  = cpu_addr_i;
      mst_wdata = cpu_wdata_i;
      mst_wstrb = cpu_wstrb_i;
    end

    xfer_live = busy && mst_valid;
    // A slave answer in the watchdog's last cycle still counts as a normal completion.
    slv_done  = xfer_live && slv_ready_i;
    tmo_hit   = xfer_live && !slv_ready_i && (tmo_cnt_q == TMO_MAX);
    mst_ready = slv_done || tmo_hit;
    mst_rdata = tmo_hit ? ERR_RDATA : slv_rdata_i;

    if (busy) begin
      slv_valid_o = mst_valid;
      slv_addr_o  = mst_addr;
      slv_wdata_o = mst_wdata;
      slv_wstrb_o = mst_wstrb;
    end

    if (mst_ready) begin
      if (gnt_q) begin
        dma_ready_o = 1'b1;
        dma_rdata_o = mst_rdata;
      end else begin
        cpu_ready_o = 1'b1;
        cpu_rdata_o = mst_rdata;
      end
    end
  end

  // Arbitration FSM, watchdog counter and sticky error capture.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      rr_ptr_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
      err_mst_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_valid_i || dma_valid_i) begin
            gnt_q     <= (cpu_valid_i && dma_valid_i) ? rr_ptr_q : dma_valid_i;
            tmo_cnt_q <= '0;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!mst_valid) begin
            state_q <= ST_IDLE;
          end else if (mst_ready) begin
            rr_ptr_q <= ~gnt_q;
            state_q  <= ST_IDLE;
          end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A timeout in the same cycle as a clear keeps the error set.
      if (tmo_hit) begin
        err_q      <= 1'b1;
        err_mst_q  <= gnt_q;
        err_addr_q <= mst_addr;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err_o      = err_q;
  assign err_mst_o  = err_mst_q;
  assign err_addr_o = err_addr_q;
  assign busy_o     = (state_q == ST_BUSY);

endmodule

// File: tb/tb_nmi_bus_arb.sv
// Scoreboard bench for nmi_bus_arb: expected responses are queued as stimulus is
// driven and matched against every master ready pulse seen on the ports.
module tb_nmi_bus_arb;

  localparam int unsigned TMO = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [31:0] AUTO_X = 32'h5A5A_5A5A;

  typedef struct packed {
    logic [1:0]  mst;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cpu_valid_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wdata_i = '0;
  logic [3:0]  cpu_wstrb_i = '0;
  logic        cpu_ready_o;
  logic [31:0] cpu_rdata_o;
  logic        dma_valid_i = 1'b0;
  logic [31:0] dma_addr_i = '0;
  logic [31:0] dma_wdata_i = '0;
  logic [3:0]  dma_wstrb_i = '0;
  logic        dma_ready_o;
  logic [31:0] dma_rdata_o;
  logic        slv_valid_o;
  logic [31:0] slv_addr_o;
  logic [31:0] slv_wdata_o;
  logic [3:0]  slv_wstrb_o;
  logic        slv_ready_i = 1'b0;
  logic [31:0] slv_rdata_i = '0;
  logic        err_clr_i = 1'b0;
  logic        err_o;
  logic        err_mst_o;
  logic [31:0] err_addr_o;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  int          slv_mode = 0;   // 0 silent, 1 zero-wait, 2 answer in BUSY cycle sched_cyc
  int          sched_cyc = 0;
  logic [31:0] sched_data = '0;
  int          bcnt = 0;

  rsp_t exp_q[$];
  rsp_t obs_mem [0:63];
  int   obs_n = 0;

  always #5 clk = ~clk;

  nmi_bus_arb #(.TIMEOUT_CYC(TMO), .ERR_RDATA(ERRD)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .cpu_valid_i(cpu_valid_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_wstrb_i(cpu_wstrb_i), .cpu_ready_o(cpu_ready_o), .cpu_rdata_o(cpu_rdata_o),
    .dma_valid_i(dma_valid_i), .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i),
    .dma_wstrb_i(dma_wstrb_i), .dma_ready_o(dma_ready_o), .dma_rdata_o(dma_rdata_o),
    .slv_valid_o(slv_valid_o), .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o),
    .slv_wstrb_o(slv_wstrb_o), .slv_ready_i(slv_ready_i), .slv_rdata_i(slv_rdata_i),
    .err_clr_i(err_clr_i), .err_o(err_o), .err_mst_o(err_mst_o),
    .err_addr_o(err_addr_o), .busy_o(busy_o)
  );

  // Slave model, updated shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (busy_o) bcnt = bcnt + 1;
    else bcnt = 0;
    slv_ready_i = 1'b0;
    slv_rdata_i = '0;
    if (slv_mode == 1 && slv_valid_o) begin
      slv_ready_i = 1'b1;
      slv_rdata_i = slv_addr_o ^ AUTO_X;
    end else if (slv_mode == 2 && slv_valid_o && bcnt == sched_cyc) begin
      slv_ready_i = 1'b1;
      slv_rdata_i = sched_data;
    end
  end

  // Response monitor: records every master ready pulse.
  always @(negedge clk) begin
    if (cpu_ready_o || dma_ready_o) begin
      if (obs_n < 64)
        obs_mem[obs_n] <= '{mst: (cpu_ready_o && dma_ready_o) ? 2'd2 : (dma_ready_o ? 2'd1 : 2'd0),
                            data: cpu_ready_o ? cpu_rdata_o : dma_rdata_o};
      obs_n <= obs_n + 1;
    end
  end

  task automatic do_reset();
    rst_n_i = 1'b0;
    cpu_valid_i = 1'b0;
    dma_valid_i = 1'b0;
    err_clr_i = 1'b0;
    slv_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  // Runs one single-master transfer; optionally pulses err_clr in BUSY cycle clr_b+1.
  task automatic run_xfer(input logic dma, input int ncyc, input int clr_b,
                          output int nrdy, output int rdy_b, output logic [31:0] got,
                          output int oth);
    int b;
    b = 0; nrdy = 0; rdy_b = 0; got = '0; oth = 0;
    @(posedge clk); #1;
    if (dma) dma_valid_i = 1'b1;
    else cpu_valid_i = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (busy_o) b++;
      if (dma ? dma_ready_o : cpu_ready_o) begin
        nrdy++;
        rdy_b = b;
        got = dma ? dma_rdata_o : cpu_rdata_o;
      end
      if (dma ? cpu_ready_o : dma_ready_o) oth++;
      @(posedge clk); #1;
      err_clr_i = (b == clr_b) && (nrdy == 0);
      if (nrdy > 0) begin
        if (dma) dma_valid_i = 1'b0;
        else cpu_valid_i = 1'b0;
      end
    end
    err_clr_i = 1'b0;
    cpu_valid_i = 1'b0;
    dma_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    cpu_valid_i = 1'b1;
    cpu_addr_i = 32'h1111_2222;
    dma_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (slv_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_slv_valid: got %b want 0", slv_valid_o); end
    n_vec++;
    if ({slv_addr_o, slv_wdata_o, slv_wstrb_o} !== '0) begin
      n_err++; $display("FAIL reset_slv_fields: got %h/%h/%h want 0", slv_addr_o, slv_wdata_o, slv_wstrb_o);
    end
    n_vec++;
    if ({cpu_ready_o, dma_ready_o, cpu_rdata_o, dma_rdata_o} !== '0) begin
      n_err++; $display("FAIL reset_mst_rsp: got %b %b %h %h want 0", cpu_ready_o, dma_ready_o, cpu_rdata_o, dma_rdata_o);
    end
    n_vec++;
    if ({err_o, err_mst_o, err_addr_o, busy_o} !== '0) begin
      n_err++; $display("FAIL reset_status: got err=%b mst=%b addr=%h busy=%b want 0", err_o, err_mst_o, err_addr_o, busy_o);
    end
    cpu_valid_i = 1'b0;
    dma_valid_i = 1'b0;
    rst_n_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL idle_no_req: busy got %b want 0", busy_o); end
  endtask

  task automatic test_single_read();
    int b, nrdy, rdy_b, ndma;
    logic [31:0] got;
    b = 0; nrdy = 0; rdy_b = 0; ndma = 0; got = '0;
    slv_mode = 2; sched_cyc = 3; sched_data = 32'h1234_5678;
    exp_q.push_back('{mst: 2'd0, data: 32'h1234_5678});
    @(posedge clk); #1;
    cpu_addr_i = 32'h1000_0104; cpu_wstrb_i = 4'h0; cpu_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_o) b++;
      if (i == 0) begin
        n_vec++;
        if (slv_valid_o !== 1'b0) begin n_err++; $display("FAIL grant_latency_idle: slv_valid got %b want 0", slv_valid_o); end
      end
      if (i == 1) begin
        n_vec++;
        if (slv_valid_o !== 1'b1 || slv_addr_o !== 32'h1000_0104 || slv_wstrb_o !== 4'h0) begin
          n_err++; $display("FAIL grant_latency_busy: got v=%b a=%h s=%h want 1/10000104/0", slv_valid_o, slv_addr_o, slv_wstrb_o);
        end
      end
      if (cpu_ready_o) begin nrdy++; rdy_b = b; got = cpu_rdata_o; end
      if (dma_ready_o) ndma++;
      @(posedge clk); #1;
      if (nrdy > 0) cpu_valid_i = 1'b0;
    end
    n_vec++;
    if (nrdy !== 1 || rdy_b !== 3) begin n_err++; $display("FAIL single_ready: got count=%0d cyc=%0d want 1/3", nrdy, rdy_b); end
    n_vec++;
    if (got !== 32'h1234_5678) begin n_err++; $display("FAIL single_rdata: got %h want 12345678", got); end
    n_vec++;
    if (ndma !== 0 || err_o !== 1'b0) begin n_err++; $display("FAIL single_side: got dma_rdy=%0d err=%b want 0/0", ndma, err_o); end
  endtask

  task automatic test_back_to_back();
    int nrdy, last;
    do_reset();
    slv_mode = 1;
    cpu_addr_i = 32'h1000_0200; cpu_wdata_i = 32'h1111_0001; cpu_wstrb_i = 4'h1;
    dma_addr_i = 32'h2000_0300; dma_wdata_i = 32'h2222_0002; dma_wstrb_i = 4'hC;
    for (int k = 0; k < 8; k++)
      exp_q.push_back((k % 2 == 0) ? '{mst: 2'd0, data: 32'h1000_0200 ^ AUTO_X}
                                   : '{mst: 2'd1, data: 32'h2000_0300 ^ AUTO_X});
    nrdy = 0; last = -1;
    @(posedge clk); #1;
    cpu_valid_i = 1'b1; dma_valid_i = 1'b1;
    for (int i = 0; i < 40 && nrdy < 8; i++) begin
      @(negedge clk);
      if (cpu_ready_o || dma_ready_o) begin
        n_vec++;
        if (i - last !== 2) begin n_err++; $display("FAIL b2b_spacing: xfer %0d got gap %0d want 2", nrdy, i - last); end
        last = i;
        n_vec++;
        if (cpu_ready_o && (dma_ready_o || dma_rdata_o !== '0)) begin
          n_err++; $display("FAIL b2b_ungranted: dma got rdy=%b rdata=%h want 0/0", dma_ready_o, dma_rdata_o);
        end else if (dma_ready_o && (cpu_ready_o || cpu_rdata_o !== '0)) begin
          n_err++; $display("FAIL b2b_ungranted: cpu got rdy=%b rdata=%h want 0/0", cpu_ready_o, cpu_rdata_o);
        end
        n_vec++;
        if (dma_ready_o ? ({slv_wdata_o, slv_wstrb_o} !== {32'h2222_0002, 4'hC})
                        : ({slv_wdata_o, slv_wstrb_o} !== {32'h1111_0001, 4'h1})) begin
          n_err++; $display("FAIL b2b_wmux: xfer %0d got %h/%h", nrdy, slv_wdata_o, slv_wstrb_o);
        end
        nrdy++;
      end
    end
    n_vec++;
    if (nrdy !== 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", nrdy); end
    @(posedge clk); #1;
    cpu_valid_i = 1'b0; dma_valid_i = 1'b0;
    cpu_wdata_i = '0; cpu_wstrb_i = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int nrdy, rdy_b, oth, first;
    logic [31:0] got;
    slv_mode = 0;
    dma_addr_i = 32'h1000_FF00; dma_wdata_i = 32'h0BAD_F00D; dma_wstrb_i = 4'hF;
    exp_q.push_back('{mst: 2'd1, data: ERRD});
    run_xfer(1'b1, 30, -1, nrdy, rdy_b, got, oth);
    n_vec++;
    if (nrdy !== 1 || rdy_b !== 16 || oth !== 0) begin
      n_err++; $display("FAIL tmo_ready: got count=%0d cyc=%0d cpu=%0d want 1/16/0", nrdy, rdy_b, oth);
    end
    n_vec++;
    if (got !== ERRD) begin n_err++; $display("FAIL tmo_rdata: got %h want deadbeef", got); end
    n_vec++;
    if (err_o !== 1'b1 || err_mst_o !== 1'b1 || err_addr_o !== 32'h1000_FF00) begin
      n_err++; $display("FAIL tmo_status: got %b/%b/%h want 1/1/1000ff00", err_o, err_mst_o, err_addr_o);
    end
    slv_mode = 1;
    cpu_addr_i = 32'h1000_0008; cpu_wstrb_i = 4'h0;
    exp_q.push_back('{mst: 2'd0, data: 32'h1000_0008 ^ AUTO_X});
    first = -1;
    @(posedge clk); #1;
    cpu_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ready_o && first < 0) first = i;
      @(posedge clk); #1;
      if (first >= 0) cpu_valid_i = 1'b0;
    end
    n_vec++;
    if (first !== 1 || err_o !== 1'b1) begin
      n_err++; $display("FAIL tmo_next_grant: got ready_at=%0d err=%b want 1/1", first, err_o);
    end
  endtask

  task automatic test_late_ready();
    int nrdy, rdy_b, oth;
    logic [31:0] got;
    @(posedge clk); #1; err_clr_i = 1'b1;
    @(posedge clk); #1; err_clr_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (err_o !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", err_o); end
    slv_mode = 2; sched_cyc = 16; sched_data = 32'hCAFE_0016;
    cpu_addr_i = 32'h1000_0010; cpu_wstrb_i = 4'h0;
    exp_q.push_back('{mst: 2'd0, data: 32'hCAFE_0016});
    run_xfer(1'b0, 30, -1, nrdy, rdy_b, got, oth);
    n_vec++;
    if (nrdy !== 1 || rdy_b !== 16 || got !== 32'hCAFE_0016) begin
      n_err++; $display("FAIL late_ready: got count=%0d cyc=%0d data=%h want 1/16/cafe0016", nrdy, rdy_b, got);
    end
    n_vec++;
    if (err_o !== 1'b0) begin n_err++; $display("FAIL late_ready_err: got %b want 0", err_o); end
  endtask

  task automatic test_abort_clear();
    int b, nrdy, rdy_b, oth;
    logic [31:0] got;
    slv_mode = 0; b = 0; nrdy = 0;
    cpu_addr_i = 32'h1000_0020;
    @(posedge clk); #1;
    cpu_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy_o) b++;
      if (cpu_ready_o || dma_ready_o) nrdy++;
      if (i == 2) begin
        n_vec++;
        if (busy_o !== 1'b1 || slv_valid_o !== 1'b0) begin
          n_err++; $display("FAIL abort_drop: got busy=%b slv_valid=%b want 1/0", busy_o, slv_valid_o);
        end
      end
      if (i == 3) begin
        n_vec++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_idle: busy got %b want 0", busy_o); end
      end
      @(posedge clk); #1;
      if (b == 1) cpu_valid_i = 1'b0;
    end
    n_vec++;
    if (nrdy !== 0) begin n_err++; $display("FAIL abort_ready: got %0d pulses want 0", nrdy); end

    cpu_addr_i = 32'h2000_0010;
    exp_q.push_back('{mst: 2'd0, data: ERRD});
    run_xfer(1'b0, 30, -1, nrdy, rdy_b, got, oth);
    n_vec++;
    if (err_o !== 1'b1 || err_mst_o !== 1'b0 || err_addr_o !== 32'h2000_0010) begin
      n_err++; $display("FAIL tmo_cpu_status: got %b/%b/%h want 1/0/20000010", err_o, err_mst_o, err_addr_o);
    end

    dma_addr_i = 32'h3000_0020; dma_wstrb_i = 4'h3;
    exp_q.push_back('{mst: 2'd1, data: ERRD});
    run_xfer(1'b1, 30, 15, nrdy, rdy_b, got, oth);
    n_vec++;
    if (nrdy !== 1 || rdy_b !== 16) begin n_err++; $display("FAIL clr_tmo_ready: got count=%0d cyc=%0d want 1/16", nrdy, rdy_b); end
    n_vec++;
    if (err_o !== 1'b1 || err_mst_o !== 1'b1 || err_addr_o !== 32'h3000_0020) begin
      n_err++; $display("FAIL clr_vs_tmo: got %b/%b/%h want 1/1/30000020", err_o, err_mst_o, err_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    int nrdy, first_mst;
    slv_mode = 0;
    dma_addr_i = 32'h4000_0000; dma_wstrb_i = 4'h0;
    @(posedge clk); #1;
    dma_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (busy_o !== 1'b1 || slv_valid_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: got busy=%b slv_valid=%b want 1/1", busy_o, slv_valid_o);
    end
    #1 rst_n_i = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, slv_valid_o, dma_ready_o, cpu_ready_o} !== 4'b0 || slv_addr_o !== '0 || dma_rdata_o !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: got busy=%b v=%b rdy=%b a=%h want 0", busy_o, slv_valid_o, dma_ready_o, slv_addr_o);
    end
    n_vec++;
    if ({err_o, err_mst_o, err_addr_o} !== '0) begin
      n_err++; $display("FAIL rstmid_err: got %b/%b/%h want 0", err_o, err_mst_o, err_addr_o);
    end
    slv_mode = 1;
    cpu_addr_i = 32'h1000_0040; cpu_wstrb_i = 4'h0;
    cpu_valid_i = 1'b1;
    exp_q.push_back('{mst: 2'd0, data: 32'h1000_0040 ^ AUTO_X});
    exp_q.push_back('{mst: 2'd1, data: 32'h4000_0000 ^ AUTO_X});
    @(negedge clk);
    rst_n_i = 1'b1;
    nrdy = 0; first_mst = -1;
    for (int i = 0; i < 12 && nrdy < 2; i++) begin
      @(negedge clk);
      if (cpu_ready_o || dma_ready_o) begin
        if (nrdy == 0) first_mst = dma_ready_o ? 1 : 0;
        nrdy++;
      end
      @(posedge clk); #1;
      if (nrdy >= 1) cpu_valid_i = 1'b0;
      if (nrdy >= 2) dma_valid_i = 1'b0;
    end
    cpu_valid_i = 1'b0; dma_valid_i = 1'b0;
    n_vec++;
    if (first_mst !== 0 || nrdy !== 2) begin
      n_err++; $display("FAIL rstmid_regrant: got first=%0d count=%0d want 0/2", first_mst, nrdy);
    end
  endtask

  task automatic test_scoreboard();
    rsp_t e;
    n_vec++;
    if (obs_n !== exp_q.size()) begin
      n_err++; $display("FAIL sb_count: got %0d responses want %0d", obs_n, exp_q.size());
    end
    for (int i = 0; i < obs_n && i < 64 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_mem[i] !== e) begin
        n_err++; $display("FAIL sb_rsp%0d: got mst=%0d data=%h want mst=%0d data=%h",
                          i, obs_mem[i].mst, obs_mem[i].data, e.mst, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_timeout();
    test_late_ready();
    test_abort_clear();
    test_reset_mid();
    repeat (2) @(negedge clk);
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
